// File: rtl/inst_prefetch_buffer.sv
// Sequential instruction prefetch queue between the fetch port and a combinational ROM.
// Optional same-cycle ROM-to-core bypass on an empty queue: define FETCH_BYPASS_EN.
module inst_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        pop_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic [31:0]   fetch_pc;
  logic          q_valid;
  logic          push;
  logic          pop_q;
  logic          unused_flush_lsbs;

  assign unused_flush_lsbs = ^flush_pc_i[1:0];

  // Chip enable depends only on reset, flush and registered occupancy, never on pop_i.
  assign rom_ce_o   = !rst && !flush_i && (count < DEPTH_C);
  assign rom_addr_o = fetch_pc;
  assign q_valid    = (count != '0);
  assign pop_q      = pop_i && q_valid && !flush_i;

`ifdef FETCH_BYPASS_EN
  logic bypass;

  always_comb begin
    bypass       = !q_valid && rom_ce_o;
    inst_valid_o = q_valid || bypass;
    inst_o       = '0;
    inst_pc_o    = '0;
    if (q_valid) begin
      inst_o    = inst_mem[rd_ptr];
      inst_pc_o = pc_mem[rd_ptr];
    end else if (bypass) begin
      inst_o    = rom_data_i;
      inst_pc_o = fetch_pc;
    end
    // A bypassed word consumed the same cycle is never stored.
    push = rom_ce_o && !(bypass && pop_i);
  end
`else
  always_comb begin
    inst_valid_o = q_valid;
    inst_o       = '0;
    inst_pc_o    = '0;
    if (q_valid) begin
      inst_o    = inst_mem[rd_ptr];
      inst_pc_o = pc_mem[rd_ptr];
    end
    push = rom_ce_o;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= RESET_PC;
    end else if (flush_i) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= {flush_pc_i[31:2], 2'b00};
    end else begin
      if (push)     wr_ptr   <= wr_ptr + 1'b1;
      if (pop_q)    rd_ptr   <= rd_ptr + 1'b1;
      if (rom_ce_o) fetch_pc <= fetch_pc + 32'd4;
      unique case ({push, pop_q})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= rom_data_i;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Scoreboard bench for inst_prefetch_buffer (default build, DEPTH=4, ROM word k = k).
module tb_inst_prefetch_buffer;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        pop_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t      exp_q[$];
  logic [31:0] model_pc;
  int          n_checks = 0;
  int          n_fail   = 0;

  inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .pop_i        (pop_i),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_valid_o (inst_valid_o),
    .rom_ce_o     (rom_ce_o),
    .rom_addr_o   (rom_addr_o),
    .rom_data_i   (rom_data_i)
  );

  always #5 clk = ~clk;

  assign rom_data_i = {2'b00, rom_addr_o[31:2]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
    check({tag, "_ce"},    32'(rom_ce_o),     32'd0);
    check({tag, "_inst"},  inst_o,            32'd0);
    check({tag, "_pc"},    inst_pc_o,         32'd0);
    check({tag, "_addr"},  rom_addr_o,        RESET_PC);
  endtask

  // Called just after a falling edge: drive, compare against the model, advance the model.
  task automatic step(input logic flush, input logic [31:0] fpc, input logic pop);
    logic exp_ce;
    flush_i    = flush;
    flush_pc_i = fpc;
    pop_i      = pop;
    #1;
    exp_ce = !flush && (exp_q.size() < DEPTH);
    check("rom_ce",   32'(rom_ce_o),     32'(exp_ce));
    check("rom_addr", rom_addr_o,        model_pc);
    check("valid",    32'(inst_valid_o), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("head_pc",   inst_pc_o, exp_q[0].pc);
      check("head_inst", inst_o,    exp_q[0].inst);
    end else begin
      check("idle_pc",   inst_pc_o, 32'd0);
      check("idle_inst", inst_o,    32'd0);
    end
    if (flush) begin
      exp_q.delete();
      model_pc = {fpc[31:2], 2'b00};
    end else begin
      if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
      if (exp_ce) begin
        exp_q.push_back({{2'b00, model_pc[31:2]}, model_pc});
        model_pc = model_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int unsigned n, input logic pop);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 32'd0, pop);
  endtask

  task automatic release_reset();
    rst = 1'b0;
    exp_q.delete();
    model_pc = RESET_PC;
  endtask

  initial begin
    rst        = 1'b1;
    flush_i    = 1'b0;
    flush_pc_i = '0;
    pop_i      = 1'b0;
    model_pc   = RESET_PC;
    @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    release_reset();

    // Fill with no pops, then sit full.
    run(7, 1'b0);
    // Single pop on a full queue, fetch resumes at 16.
    step(1'b0, 32'd0, 1'b1);
    run(2, 1'b0);
    // Steady streaming.
    run(10, 1'b1);
    // Flush with simultaneous pop; misaligned target.
    step(1'b1, 32'h0000_0103, 1'b1);
    run(4, 1'b1);
    // Address wrap.
    step(1'b1, 32'hFFFF_FFF8, 1'b0);
    run(6, 1'b0);
    run(4, 1'b1);
    // Back-to-back flushes.
    step(1'b1, 32'h0000_0040, 1'b1);
    step(1'b1, 32'h0000_0080, 1'b0);
    run(3, 1'b0);
    // Random traffic.
    for (int unsigned i = 0; i < 60; i++)
      step(($urandom_range(0, 15) == 0), $urandom, 1'(($urandom_range(0, 2)) != 0));

    // Async reset with three entries held.
    rst = 1'b1;
    @(negedge clk);
    release_reset();
    run(3, 1'b0);
    check("mid_count", 32'(exp_q.size()), 32'd3);
    check("mid_valid_pre", 32'(inst_valid_o), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    #1 check_reset_outputs("rst_held");
    release_reset();
    // Stream with pop held high from reset release.
    run(8, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
